// File: rtl/rcpa1_serial_sub.sv
// Bit-serial approximate subtractor. The low APPROX_BITS bits are formed as
// a ^ b with no borrow; the upper bits form an exact ripple-borrow difference.
// An exact difference is computed alongside from the same shifted operands.
module rcpa1_serial_sub #(
  parameter int N           = 8,
  parameter int APPROX_BITS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow_out,
  output logic [N-1:0] exact_diff,
  output logic         exact_borrow
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW:0]   AB   = (CW+1)'(APPROX_BITS);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  a_sh, b_sh;
  logic [N-1:0]  acc_a, acc_e;
  logic [CW-1:0] cnt;
  logic          bra, bre;

  logic ba, bb, apx_lo;
  logic da, de, bra_n, bre_n;

  // Per-bit difference and next borrow for both paths at bit position cnt
  always_comb begin
    ba     = a_sh[0];
    bb     = b_sh[0];
    apx_lo = ({1'b0, cnt} < AB);
    de     = ba ^ bb ^ bre;
    bre_n  = (~ba & bb) | (~(ba ^ bb) & bre);
    da     = ba ^ bb;
    bra_n  = 1'b0;
    if (!apx_lo) begin
      da    = ba ^ bb ^ bra;
      bra_n = (~ba & bb) | (~(ba ^ bb) & bra);
    end
  end

  // Control FSM with datapath; result registers only load on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      a_sh         <= '0;
      b_sh         <= '0;
      acc_a        <= '0;
      acc_e        <= '0;
      cnt          <= '0;
      bra          <= 1'b0;
      bre          <= 1'b0;
      diff         <= '0;
      exact_diff   <= '0;
      borrow_out   <= 1'b0;
      exact_borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= A;
            b_sh     <= B;
            cnt      <= '0;
            bra      <= 1'b0;
            bre      <= 1'b0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc_a <= {da, acc_a[N-1:1]};
          acc_e <= {de, acc_e[N-1:1]};
          bra   <= bra_n;
          bre   <= bre_n;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff         <= {da, acc_a[N-1:1]};
            exact_diff   <= {de, acc_e[N-1:1]};
            borrow_out   <= bra_n;
            exact_borrow <= bre_n;
            out_valid    <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rcpa1_serial_sub.sv
// Directed bench for rcpa1_serial_sub: APPROX_BITS=2 main instance, plus
// APPROX_BITS=0 (random, must equal exact) and APPROX_BITS=8 (pure XOR).
module tb_rcpa1_serial_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance, APPROX_BITS = 2
  logic       iv2 = 0, ir2, ov2, or2 = 1, bo2, eb2;
  logic [7:0] a2 = 0, b2 = 0, d2, ed2;
  // APPROX_BITS = 0
  logic       iv0 = 0, ir0, ov0, or0 = 1, bo0, eb0;
  logic [7:0] a0 = 0, b0 = 0, d0, ed0;
  // APPROX_BITS = 8
  logic       iv8 = 0, ir8, ov8, or8 = 1, bo8, eb8;
  logic [7:0] a8 = 0, b8 = 0, d8, ed8;

  rcpa1_serial_sub #(.N(8), .APPROX_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
    .out_valid(ov2), .out_ready(or2), .diff(d2), .borrow_out(bo2),
    .exact_diff(ed2), .exact_borrow(eb2));
  rcpa1_serial_sub #(.N(8), .APPROX_BITS(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
    .out_valid(ov0), .out_ready(or0), .diff(d0), .borrow_out(bo0),
    .exact_diff(ed0), .exact_borrow(eb0));
  rcpa1_serial_sub #(.N(8), .APPROX_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow_out(bo8),
    .exact_diff(ed8), .exact_borrow(eb8));

  int npass = 0;
  int ntot  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // handshake one operand pair into the main instance and wait for its result
  task automatic op2(input logic [7:0] a, input logic [7:0] b);
    a2 = a; b2 = b; iv2 = 1'b1;
    tick();
    iv2 = 1'b0; a2 = ~a; b2 = ~b;
    for (int i = 0; i < 20 && !ov2; i++) tick();
    chk("op2_out_valid", {31'd0, ov2}, 32'd1);
  endtask

  initial begin
    logic [7:0] ra, rb, ea;
    logic       eb;
    int         done;

    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, ir2}, 32'd1);
    chk("rst_out_valid", {31'd0, ov2}, 32'd0);
    chk("rst_diff", {24'd0, d2}, 32'h00);
    chk("rst_exact_diff", {24'd0, ed2}, 32'h00);
    chk("rst_borrows", {30'd0, bo2, eb2}, 32'd0);

    // 0x35 - 0x12: latency check, out_ready already high
    a2 = 8'h35; b2 = 8'h12; iv2 = 1'b1;
    tick();
    iv2 = 1'b0; a2 = 8'hFF; b2 = 8'hFF;
    chk("run_in_ready", {31'd0, ir2}, 32'd0);
    for (int i = 0; i < 7; i++) tick();
    chk("lat_not_yet", {31'd0, ov2}, 32'd0);
    tick();
    chk("lat_out_valid", {31'd0, ov2}, 32'd1);
    chk("op1_diff", {24'd0, d2}, 32'h27);
    chk("op1_borrow", {31'd0, bo2}, 32'd0);
    chk("op1_exact_diff", {24'd0, ed2}, 32'h23);
    chk("op1_exact_borrow", {31'd0, eb2}, 32'd0);
    tick();
    chk("op1_back_idle", {30'd0, ir2, ov2}, 32'b10);

    // 0x05 - 0x07
    op2(8'h05, 8'h07);
    chk("op2_diff", {24'd0, d2}, 32'h02);
    chk("op2_borrow", {31'd0, bo2}, 32'd0);
    chk("op2_exact_diff", {24'd0, ed2}, 32'hFE);
    chk("op2_exact_borrow", {31'd0, eb2}, 32'd1);
    tick();

    // 0x10 - 0x01 with the consumer stalling
    or2 = 1'b0;
    op2(8'h10, 8'h01);
    for (int i = 0; i < 5; i++) begin
      chk("hold_diff", {24'd0, d2}, 32'h11);
      chk("hold_exact_diff", {24'd0, ed2}, 32'h0F);
      chk("hold_in_ready", {31'd0, ir2}, 32'd0);
      chk("hold_out_valid", {31'd0, ov2}, 32'd1);
      tick();
    end
    or2 = 1'b1;
    chk("hold_in_ready_same_cycle", {31'd0, ir2}, 32'd0);
    tick();
    chk("hold_released", {30'd0, ir2, ov2}, 32'b10);

    // reset during the 4th RUN cycle drops the operation
    a2 = 8'hAA; b2 = 8'h55; iv2 = 1'b1;
    tick();
    iv2 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", {31'd0, ir2}, 32'd1);
    chk("midrst_out_valid", {31'd0, ov2}, 32'd0);
    chk("midrst_diffs", {d2, ed2}, 32'h0);
    chk("midrst_borrows", {30'd0, bo2, eb2}, 32'd0);
    op2(8'h00, 8'h01);
    chk("post_rst_diff", {24'd0, d2}, 32'h01);
    chk("post_rst_borrow", {31'd0, bo2}, 32'd0);
    chk("post_rst_exact_diff", {24'd0, ed2}, 32'hFF);
    chk("post_rst_exact_borrow", {31'd0, eb2}, 32'd1);
    tick();

    // APPROX_BITS = 0: back-to-back random ops, in_valid held high throughout
    done = 0; ea = 0; eb = 0;
    iv0 = 1'b1;
    for (int cyc = 0; cyc < 5000 && done < 200; cyc++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      a0 = ra; b0 = rb;
      if (ir0) begin
        ea = ra - rb;
        eb = (ra < rb);
      end
      tick();
      if (ov0) begin
        chk("apx0_exact_diff", {24'd0, ed0}, {24'd0, ea});
        chk("apx0_exact_borrow", {31'd0, eb0}, {31'd0, eb});
        chk("apx0_diff_eq", {24'd0, d0}, {24'd0, ea});
        chk("apx0_borrow_eq", {31'd0, bo0}, {31'd0, eb});
        done++;
      end
    end
    iv0 = 1'b0;
    chk("apx0_op_count", done, 200);

    // APPROX_BITS = N: pure XOR difference
    a8 = 8'hF0; b8 = 8'h3C; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    for (int i = 0; i < 20 && !ov8; i++) tick();
    chk("apx8_out_valid", {31'd0, ov8}, 32'd1);
    chk("apx8_diff", {24'd0, d8}, 32'hCC);
    chk("apx8_borrow", {31'd0, bo8}, 32'd0);
    chk("apx8_exact_diff", {24'd0, ed8}, 32'hB4);
    chk("apx8_exact_borrow", {31'd0, eb8}, 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/rcpa1_serial_sub.md
Name: rcpa1_serial_sub

Overview:
- Bit-serial approximate subtractor; the subtract-side counterpart of the combinational N-bit approximate ripple adders.
- Computes the approximate difference A - B one bit per cycle, LSB first.
- Computes the exact difference in parallel with the approximate one, so error-characterisation benches compare both from one transaction.
- Sits behind a valid/ready operand interface and holds its result until the consumer takes it.

Parameters:
- N, 8, operand and result width in bits (N >= 2).
- APPROX_BITS, 2, number of low-order bits computed without borrow (0 <= APPROX_BITS <= N); 0 gives exact behaviour.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands A, B are valid.
- in_ready  output  1  block can accept operands.
- A  input  N  minuend.
- B  input  N  subtrahend.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  N  approximate difference.
- borrow_out  output  1  approximate borrow out of bit N-1.
- exact_diff  output  N  exact (A - B) mod 2^N.
- exact_borrow  output  1  1 when A < B (unsigned).

Behaviour:
- Reset is synchronous and active-high, with a single clock (clk, rst).
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - diff, exact_diff, borrow_out, exact_borrow all 0.
  - Bit counter and both internal borrows 0.
- rst overrides every other input, including mid-RUN and while in DONE; the in-flight operation is dropped with no output.
- State machine, three states:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch A and B into shift registers, clear the counter and both borrows, then go to RUN.
  - RUN: in_ready = 0, out_valid = 0. Each cycle processes bit i = counter, LSB first, then increments the counter. After bit N-1 (exactly N RUN cycles) go to DONE.
  - DONE: out_valid = 1, outputs stable. On out_ready, go to IDLE. If out_ready is already high on entry, the handshake completes in that first DONE cycle.
- Exact path, every bit: d = a ^ b ^ br; br' = (~a & b) | (~(a ^ b) & br).
- Approximate path:
  - For i < APPROX_BITS: d = a ^ b, no borrow generated, borrow held at 0.
  - For i >= APPROX_BITS: same equations as the exact path, with the borrow into bit APPROX_BITS equal to 0.
  - Equivalent to {A_hi - B_hi, A_lo ^ B_lo}.
- borrow_out / exact_borrow: final borrow after bit N-1 of the respective path.
- Timing and throughput:
  - Latency: operand handshake in cycle 0, out_valid high in cycle N+1.
  - Throughput: one operation per N+2 cycles at minimum; no new operand is accepted in DONE.
- Outputs change only on entry to DONE; they keep their last values through IDLE and RUN.
- in_valid is ignored outside IDLE. A and B may change freely after the handshake.
- APPROX_BITS = N: diff = A ^ B and borrow_out = 0.

Test Plan:
- Reset, then A=0x35, B=0x12 (N=8, APPROX_BITS=2) -> out_valid in cycle 9, diff=0x27, borrow_out=0, exact_diff=0x23, exact_borrow=0.
- A=0x05, B=0x07 -> diff=0x02, borrow_out=0, exact_diff=0xFE, exact_borrow=1.
- A=0x10, B=0x01 with out_ready held low for 5 cycles -> diff=0x11 and exact_diff=0x0F stay stable, in_ready=0 until the cycle after out_ready rises.
- rst asserted in the 4th RUN cycle -> next cycle in_ready=1, out_valid=0, all outputs 0; a new A=0x00, B=0x01 then gives diff=0x01, exact_diff=0xFF, exact_borrow=1.
- APPROX_BITS=0, 200 random operand pairs with back-to-back handshakes -> diff == exact_diff and borrow_out == exact_borrow every time; in_valid pulses during RUN/DONE are ignored.
- APPROX_BITS=N=8, A=0xF0, B=0x3C -> diff=0xCC, borrow_out=0, exact_diff=0xB4.
